// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data memory responder: MMIO map,
// TX_STATUS bit layout and the MMIO register decoder.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE      = 32'hFFFF_0000;
  localparam logic [31:0] CYCLE_ADDR     = 32'hFFFF_0000;
  localparam logic [31:0] TX_DATA_ADDR   = 32'hFFFF_0004;
  localparam logic [31:0] TX_STATUS_ADDR = 32'hFFFF_0008;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_COUNT_W   = 4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CYCLE,
    SEL_TX_DATA,
    SEL_TX_STATUS
  } mmio_sel_e;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:16] == MMIO_BASE[31:16];
  endfunction

  function automatic mmio_sel_e mmio_decode(input logic [31:0] addr);
    mmio_sel_e sel;
    sel = SEL_NONE;
    if (addr == CYCLE_ADDR)          sel = SEL_CYCLE;
    else if (addr == TX_DATA_ADDR)   sel = SEL_TX_DATA;
    else if (addr == TX_STATUS_ADDR) sel = SEL_TX_STATUS;
    return sel;
  endfunction

  function automatic logic [31:0] status_word(input logic [ST_COUNT_W-1:0] count,
                                              input logic overflow,
                                              input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_COUNT_LSB +: ST_COUNT_W] = count;
    w[ST_OVF_BIT]   = overflow;
    w[ST_FULL_BIT]  = full;
    w[ST_EMPTY_BIT] = empty;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the TX stream. A push while full is dropped (sticky
// overflow) unless a pop completes in the same cycle.
module tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          clr_overflow,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic          pop_fire;
  logic          push_fire;
  logic          drop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head      = mem[rptr];
  // A pop from an empty FIFO is void, so a coinciding push is never bypassed.
  assign pop_fire  = en & pop & ~empty;
  assign push_fire = en & push & (~full | pop_fire);
  assign drop      = en & push & full & ~pop_fire;

  always_ff @(posedge clk) begin
    if (push_fire) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_fire) wptr <= next_ptr(wptr);
      if (pop_fire)  rptr <= next_ptr(rptr);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                    overflow <= 1'b1;
      else if (en & clr_overflow)  overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Byte-lane data RAM with registered 1-cycle reads. Define DMEM_MMIO_EN to add
// the MMIO window at 0xFFFF_xxxx (CYCLE counter, TX FIFO data/status).
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned TX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mem_read_en,
  input  logic [3:0]  mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          ram_sel;
  logic [31:0]   ram_rdata;
  logic [31:0]   rd_next;

  assign word_idx  = mem_addr[AW+1:2];
  assign ram_rdata = ram[word_idx];

`ifdef DMEM_MMIO_EN
  localparam int unsigned CW = $clog2(TX_DEPTH + 1);

  mmio_sel_e     sel;
  logic [31:0]   cycle;
  logic [31:0]   mmio_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  assign sel     = mmio_decode(mem_addr);
  assign ram_sel = ~is_mmio(mem_addr);

  always_ff @(posedge clk) begin
    if (rst)     cycle <= '0;
    else if (en) cycle <= cycle + 1'b1;
  end

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .push         ((sel == SEL_TX_DATA) & (|mem_write_en)),
    .push_data    (mem_write_data[7:0]),
    .pop          (tx_ready),
    .clr_overflow ((sel == SEL_TX_STATUS) & (|mem_write_en)),
    .head         (fifo_head),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .overflow     (fifo_ovf)
  );

  always_comb begin
    mmio_rdata = '0;
    case (sel)
      SEL_CYCLE:     mmio_rdata = cycle;
      SEL_TX_STATUS: mmio_rdata = status_word(ST_COUNT_W'(fifo_count), fifo_ovf,
                                              fifo_full, fifo_empty);
      default:       mmio_rdata = '0;
    endcase
  end

  assign rd_next  = ram_sel ? ram_rdata : mmio_rdata;
  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_head;
`else
  logic unused_bits;

  assign ram_sel     = 1'b1;
  assign rd_next     = ram_rdata;
  assign tx_valid    = 1'b0;
  assign tx_data     = '0;
  assign unused_bits = ^{mem_addr[31:AW+2], tx_ready};
`endif

  // Reads sample the array before this edge's write lands, giving old data.
  always_ff @(posedge clk) begin
    if (en & ram_sel & ~rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_write_en[i]) ram[word_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     mem_read_data <= '0;
    else if (en & mem_read_en)   mem_read_data <= rd_next;
  end

  logic unused_lsb;
  assign unused_lsb = ^mem_addr[1:0];

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized + directed bench for data_memory_responder with a queue-based
// reference model; covers the MMIO window when DMEM_MMIO_EN is defined.
module tb_data_memory_responder;

  localparam int unsigned DW = 64;
  localparam int unsigned TD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        mem_read_en = 1'b0;
  logic [3:0]  mem_write_en = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .DEPTH_WORDS (DW),
    .TX_DEPTH    (TD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready)
  );

  typedef struct {
    logic [31:0] rd;
    bit          txv;
    logic [7:0]  txd;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_ram [DW];
  logic [31:0] m_rd = '0;
  logic [31:0] m_cycle = '0;
  logic [7:0]  m_q[$];
  bit          m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a[31:16] == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle, advance the model, and queue the post-edge expectation.
  task automatic step(input bit r, input bit e, input bit rd, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    exp_t        x;
    logic [31:0] rv;
    int unsigned idx;
    bit          mm;
    bit          pop_ok;
    rst = r; en = e; mem_read_en = rd; mem_write_en = we;
    mem_addr = a; mem_write_data = wd; tx_ready = rdy;
    idx = (a >> 2) % DW;
    mm  = tb_is_mmio(a);
    if (r) begin
      m_rd = '0; m_cycle = '0; m_q.delete(); m_ovf = 1'b0;
    end else if (e) begin
      rv = '0;
      if (!mm) rv = m_ram[idx];
      else if (a == 32'hFFFF_0000) rv = m_cycle;
      else if (a == 32'hFFFF_0008)
        rv = {24'b0, 4'(m_q.size()), 1'b0, m_ovf, m_q.size() == TD, m_q.size() == 0};
      if (rd) m_rd = rv;
      pop_ok = rdy && (m_q.size() > 0);
      if (pop_ok) void'(m_q.pop_front());
      if (mm) begin
        if (we != 0 && a == 32'hFFFF_0004) begin
          if (m_q.size() < TD) m_q.push_back(wd[7:0]);
          else m_ovf = 1'b1;
        end
        if (we != 0 && a == 32'hFFFF_0008) m_ovf = 1'b0;
      end else begin
        for (int l = 0; l < 4; l++)
          if (we[l]) m_ram[idx][8*l +: 8] = wd[8*l +: 8];
      end
      m_cycle = m_cycle + 1;
    end
    x.rd  = m_rd;
    x.txv = m_q.size() > 0;
    x.txd = (m_q.size() > 0) ? m_q[0] : 8'h00;
    @(posedge clk);
    expq.push_back(x);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                    input bit rdy);
    step(1'b0, 1'b1, 1'b0, we, a, d, rdy);
  endtask

  task automatic rdw(input logic [31:0] a, input bit rdy);
    step(1'b0, 1'b1, 1'b1, 4'h0, a, 32'h0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, rdy);
  endtask

  // Monitor: one expectation per clock edge, checked at the following negedge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        x = expq.pop_front();
        chk("mem_read_data", mem_read_data, x.rd);
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, x.txv});
        if (x.txv) chk("tx_data", {24'b0, tx_data}, {24'b0, x.txd});
`ifndef DMEM_MMIO_EN
        chk("tx_data_tied", {24'b0, tx_data}, 32'h0);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int          k;
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < DW; i++) wr(32'(i * 4), $urandom, 4'hF, 1'b0);

    // byte-lane merge and old-data-on-collision
    wr(32'h10, 32'h1122_3344, 4'hF, 1'b0);
    wr(32'h10, 32'hAAAA_AAAA, 4'b0100, 1'b0);
    rdw(32'h10, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h5555_5555, 1'b0);
    rdw(32'h0001_0010, 1'b0);

    // stall hold, including a write that must not land while frozen
    rdw(32'h14, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'hF, 32'h14, 32'hFFFF_FFFF, 1'b1);
    rdw(32'h14, 1'b0);

`ifdef DMEM_MMIO_EN
    rdw(32'hFFFF_0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 32'hFFFF_0000, 32'h0, 1'b1);
    rdw(32'hFFFF_0000, 1'b0);

    // fill past capacity, then drain in order
    for (int i = 0; i < 9; i++) wr(32'hFFFF_0004, 32'(8'h41 + i), 4'h1, 1'b0);
    rdw(32'hFFFF_0008, 1'b0);
    idle(9, 1'b1);
    rdw(32'hFFFF_0008, 1'b0);
    wr(32'hFFFF_0008, 32'h0, 4'h8, 1'b0);
    rdw(32'hFFFF_0008, 1'b0);

    // push and pop together while full
    for (int i = 0; i < 8; i++) wr(32'hFFFF_0004, 32'(8'h61 + i), 4'h1, 1'b0);
    wr(32'hFFFF_0004, 32'h5A, 4'h2, 1'b1);
    rdw(32'hFFFF_0008, 1'b0);
    idle(9, 1'b1);

    // push and pop together while empty
    wr(32'hFFFF_0004, 32'h77, 4'h1, 1'b1);
    rdw(32'hFFFF_0008, 1'b0);
    idle(2, 1'b1);

    // unmapped MMIO and TX_DATA read
    wr(32'hFFFF_000C, 32'h1234_5678, 4'hF, 1'b0);
    rdw(32'hFFFF_000C, 1'b0);
    rdw(32'hFFFF_0004, 1'b0);
    rdw(32'h0000_000C, 1'b0);

    // reset with bytes queued
    for (int i = 0; i < 3; i++) wr(32'hFFFF_0004, 32'(8'hC0 + i), 4'h1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    rdw(32'hFFFF_0000, 1'b1);
    rdw(32'hFFFF_0008, 1'b1);
    rdw(32'h10, 1'b1);
`else
    wr(32'hFFFF_0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rdw(32'h0000_0004, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    rdw(32'h0000_0004, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
`ifdef DMEM_MMIO_EN
      if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
      if (k < 3) a = 32'hFFFF_0000 + 32'($urandom_range(0, 4) * 4);
`endif
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
           a, $urandom, $urandom_range(0, 1) == 1);
    end
    idle(2, 1'b0);

    for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
